// File: rtl/pic_pkg.sv
// Shared constants, FSM encodings and helpers for the 8259A
// priority resolver.
package pic_pkg;

    localparam int NUM_IR = 8;

    localparam logic [2:0] OCW2_NSEOI        = 3'b001;
    localparam logic [2:0] OCW2_SEOI         = 3'b011;
    localparam logic [2:0] OCW2_ROT_NSEOI    = 3'b101;
    localparam logic [2:0] OCW2_ROT_SEOI     = 3'b111;
    localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_ACK2 = 2'd2
    } ack_state_t;

    // 0 is the highest priority; lp is the lowest-priority level
    function automatic logic [2:0] rank(
        input logic [2:0] i,
        input logic [2:0] lp
    );
        return i - lp - 3'd1;
    endfunction

    function automatic logic [7:0] onehot(input logic [2:0] i);
        return 8'd1 << i;
    endfunction

endpackage

// File: rtl/pic_rot_prio_enc.sv
// Rotating priority encoder: finds the set bit closest above
// the lowest-priority pointer, wrapping modulo 8.
module pic_rot_prio_enc
    import pic_pkg::*;
(
    input  logic [7:0] i_vec,
    input  logic [2:0] i_lp,
    output logic       o_found,
    output logic [2:0] o_idx
);

    always_comb begin
        logic [2:0] w_pos;
        w_pos   = 3'd0;
        o_found = 1'b0;
        o_idx   = 3'd0;
        for (int k = NUM_IR - 1; k >= 0; k--) begin
            w_pos = i_lp + 3'd1 + 3'(k);
            if (i_vec[w_pos]) begin
                o_found = 1'b1;
                o_idx   = w_pos;
            end
        end
    end

endmodule

// File: rtl/pic_priority_resolver.sv
// 8259A IRR/ISR holder, fully nested priority resolver and
// INTA acknowledge sequencer.
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ir,
    input  logic [7:0] imr,
    input  logic       ltim,
    input  logic       aeoi,
    input  logic       init,
    input  logic [7:0] ocw2,
    input  logic       ocw2_valid,
    input  logic       first_ack,
    input  logic       second_ack,
    output logic       int_out,
    output logic [2:0] int_vec,
    output logic       int_valid,
    output logic [7:0] irr,
    output logic [7:0] isr
);

    logic [7:0] r_irr, r_isr, r_ir_q;
    logic [2:0] r_lp, r_int_vec;
    logic       r_rot_aeoi, r_int_out, r_spur;
    logic       r_fa_q, r_sa_q;
    ack_state_t r_state, w_next;

    logic       w_req_found, w_isr_found, w_win;
    logic [2:0] w_req_idx, w_isr_idx;
    logic       w_fa_rise, w_sa_rise, w_sa_fall;
    logic       w_ack_take, w_aeoi_done;
    logic [7:0] w_ack_set, w_eoi_clr, w_aeoi_clr;
    logic [7:0] w_irr_n, w_isr_n;
    logic       w_lp_ld, w_rot_set, w_rot_clr;
    logic [2:0] w_lp_val, w_cmd, w_l;
    logic       w_unused_ocw2;

    assign w_cmd         = ocw2[7:5];
    assign w_l           = ocw2[2:0];
    assign w_unused_ocw2 = ^ocw2[4:3];

    pic_rot_prio_enc u_req_enc (
        .i_vec   (r_irr & ~imr),
        .i_lp    (r_lp),
        .o_found (w_req_found),
        .o_idx   (w_req_idx)
    );

    pic_rot_prio_enc u_isr_enc (
        .i_vec   (r_isr),
        .i_lp    (r_lp),
        .o_found (w_isr_found),
        .o_idx   (w_isr_idx)
    );

    // Fully nested: a request must strictly outrank any in-service level
    assign w_win = w_req_found &&
        (!w_isr_found ||
         rank(w_req_idx, r_lp) < rank(w_isr_idx, r_lp));

    assign w_fa_rise  = first_ack & ~r_fa_q;
    assign w_sa_rise  = second_ack & ~r_sa_q;
    assign w_sa_fall  = ~second_ack & r_sa_q;
    assign w_ack_take = (r_state == ST_IDLE) && w_fa_rise;
    assign w_ack_set  = (w_ack_take && w_win) ?
                        onehot(w_req_idx) : 8'd0;

    assign w_aeoi_done = (r_state == ST_ACK2) && w_sa_fall &&
                         aeoi && !r_spur;
    assign w_aeoi_clr  = w_aeoi_done ? onehot(r_int_vec) : 8'd0;

    always_comb begin
        w_eoi_clr = 8'd0;
        w_lp_ld   = 1'b0;
        w_lp_val  = r_lp;
        w_rot_set = 1'b0;
        w_rot_clr = 1'b0;
        if (ocw2_valid) begin
            unique case (w_cmd)
                OCW2_NSEOI: begin
                    if (w_isr_found) w_eoi_clr = onehot(w_isr_idx);
                end
                OCW2_SEOI: w_eoi_clr = onehot(w_l);
                OCW2_ROT_NSEOI: begin
                    if (w_isr_found) begin
                        w_eoi_clr = onehot(w_isr_idx);
                        w_lp_ld   = 1'b1;
                        w_lp_val  = w_isr_idx;
                    end
                end
                OCW2_ROT_SEOI: begin
                    w_eoi_clr = onehot(w_l);
                    w_lp_ld   = 1'b1;
                    w_lp_val  = w_l;
                end
                OCW2_SET_PRIO: begin
                    w_lp_ld  = 1'b1;
                    w_lp_val = w_l;
                end
                OCW2_ROT_AEOI_SET: w_rot_set = 1'b1;
                OCW2_ROT_AEOI_CLR: w_rot_clr = 1'b1;
                default: ;
            endcase
        end
    end

    assign w_irr_n = ltim ? (ir & ~w_ack_set) :
                     ((r_irr | (ir & ~r_ir_q)) & ir & ~w_ack_set);
    // Clears act on the old ISR; an ack set on the same bit wins
    assign w_isr_n = (r_isr & ~(w_eoi_clr | w_aeoi_clr)) | w_ack_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (init) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_fa_rise) w_next = ST_ACK1;
            ST_ACK1: if (w_sa_rise) w_next = ST_ACK2;
            ST_ACK2: if (w_sa_fall) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        int_valid = (r_state == ST_ACK2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irr      <= 8'd0;
            r_isr      <= 8'd0;
            r_ir_q     <= 8'd0;
            r_lp       <= 3'd7;
            r_rot_aeoi <= 1'b0;
            r_int_out  <= 1'b0;
            r_int_vec  <= 3'd0;
            r_spur     <= 1'b0;
            r_fa_q     <= 1'b0;
            r_sa_q     <= 1'b0;
        end else begin
            r_fa_q <= first_ack;
            r_sa_q <= second_ack;
            if (init) begin
                r_irr      <= 8'd0;
                r_isr      <= 8'd0;
                r_ir_q     <= 8'd0;
                r_lp       <= 3'd7;
                r_rot_aeoi <= 1'b0;
                r_int_out  <= 1'b0;
                r_int_vec  <= 3'd0;
                r_spur     <= 1'b0;
            end else begin
                r_ir_q    <= ir;
                r_irr     <= w_irr_n;
                r_isr     <= w_isr_n;
                r_int_out <= w_win && (r_state == ST_IDLE) &&
                             !w_fa_rise;
                if (w_ack_take) begin
                    r_int_vec <= w_win ? w_req_idx : 3'd7;
                    r_spur    <= !w_win;
                end
                if (w_lp_ld) begin
                    r_lp <= w_lp_val;
                end else if (w_aeoi_done && r_rot_aeoi) begin
                    r_lp <= r_int_vec;
                end
                if (w_rot_set) begin
                    r_rot_aeoi <= 1'b1;
                end else if (w_rot_clr) begin
                    r_rot_aeoi <= 1'b0;
                end
            end
        end
    end

    assign int_out = r_int_out;
    assign int_vec = r_int_vec;
    assign irr     = r_irr;
    assign isr     = r_isr;

endmodule

// File: tb/tb_pic_priority_resolver.sv
// Directed bench: acknowledged vectors are scoreboarded by a
// monitor on int_valid; register state is checked inline.
module tb_pic_priority_resolver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ir, imr, ocw2;
    logic       ltim, aeoi, init, ocw2_valid;
    logic       first_ack, second_ack;
    logic       int_out, int_valid;
    logic [2:0] int_vec;
    logic [7:0] irr, isr;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_q[$];
    logic       prev_valid = 1'b0;

    always #5 clk = ~clk;

    pic_priority_resolver dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ir         (ir),
        .imr        (imr),
        .ltim       (ltim),
        .aeoi       (aeoi),
        .init       (init),
        .ocw2       (ocw2),
        .ocw2_valid (ocw2_valid),
        .first_ack  (first_ack),
        .second_ack (second_ack),
        .int_out    (int_out),
        .int_vec    (int_vec),
        .int_valid  (int_valid),
        .irr        (irr),
        .isr        (isr)
    );

    always @(negedge clk) begin
        if (int_valid && !prev_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL int_vec unexpected ack got=%0d", int_vec);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (int_vec !== e) begin
                    errors++;
                    $display("FAIL int_vec got=%0d exp=%0d", int_vec, e);
                end
            end
        end
        prev_valid = int_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic ocw(input logic [7:0] b);
        ocw2       = b;
        ocw2_valid = 1'b1;
        tick();
        ocw2_valid = 1'b0;
    endtask

    task automatic ack();
        first_ack  = 1'b1;
        tick();
        first_ack  = 1'b0;
        tick();
        second_ack = 1'b1;
        tick();
        tick();
        second_ack = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; ir = 8'h00; imr = 8'h00; ocw2 = 8'h00;
        ltim = 1'b0; aeoi = 1'b0; init = 1'b0; ocw2_valid = 1'b0;
        first_ack = 1'b0; second_ack = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst irr", irr, 8'h00);
        chk("rst isr", isr, 8'h00);
        chk("rst int_out", 8'(int_out), 8'h00);
        chk("rst int_valid", 8'(int_valid), 8'h00);
        chk("rst int_vec", 8'(int_vec), 8'h00);

        // edge mode, single request on IR3
        ir = 8'h08;
        tick();
        chk("t1 irr", irr, 8'h08);
        chk("t1 int_out early", 8'(int_out), 8'h00);
        tick();
        chk("t1 int_out", 8'(int_out), 8'h01);
        exp_q.push_back(3'd3);
        ack();
        chk("t1 isr", isr, 8'h08);
        chk("t1 irr after", irr, 8'h00);
        ocw(8'h20);
        chk("t1 nseoi", isr, 8'h00);
        ir = 8'h00;
        tick();

        // masking and fully nested preemption
        imr = 8'h04;
        ir  = 8'h24;
        tick(); tick();
        exp_q.push_back(3'd5);
        ack();
        chk("t2 isr", isr, 8'h20);
        chk("t2 irr", irr, 8'h04);
        imr = 8'h00;
        tick();
        chk("t2 int_out nest", 8'(int_out), 8'h01);
        exp_q.push_back(3'd2);
        ack();
        chk("t2 isr both", isr, 8'h24);
        ocw(8'h20);
        chk("t2 nseoi1", isr, 8'h20);
        ocw(8'h20);
        chk("t2 nseoi2", isr, 8'h00);
        ir = 8'h00;
        tick();

        // set priority lp=3 so IR4 is highest
        ocw(8'hC3);
        ir = 8'h11;
        tick(); tick();
        exp_q.push_back(3'd4);
        ack();
        tick();
        chk("t3 isr", isr, 8'h10);
        chk("t3 int_out blocked", 8'(int_out), 8'h00);
        ocw(8'h64);
        chk("t3 seoi", isr, 8'h00);
        exp_q.push_back(3'd0);
        ack();
        chk("t3 isr0", isr, 8'h01);
        ocw(8'h60);
        chk("t3 seoi0", isr, 8'h00);
        ocw(8'hC7);
        ir = 8'h00;
        tick();

        // AEOI with rotation
        aeoi = 1'b1;
        ocw(8'h80);
        ir = 8'h40;
        tick(); tick();
        exp_q.push_back(3'd6);
        ack();
        chk("t4 aeoi isr", isr, 8'h00);
        ir = 8'h81;
        tick(); tick();
        exp_q.push_back(3'd7);
        ack();
        chk("t4 isr7", isr, 8'h00);
        exp_q.push_back(3'd0);
        ack();
        chk("t4 irr", irr, 8'h00);
        ocw(8'h00);
        aeoi = 1'b0;
        ocw(8'hC7);
        ir = 8'h00;
        tick();

        // request withdrawn before ack -> spurious
        ir = 8'h02;
        tick(); tick();
        chk("t5 int_out", 8'(int_out), 8'h01);
        ir = 8'h00;
        tick();
        chk("t5 irr", irr, 8'h00);
        exp_q.push_back(3'd7);
        ack();
        chk("t5 isr", isr, 8'h00);

        // level mode, then init mid-sequence
        ltim = 1'b1;
        ir   = 8'h01;
        tick(); tick();
        chk("t6 int_out", 8'(int_out), 8'h01);
        exp_q.push_back(3'd0);
        ack();
        chk("t6 isr", isr, 8'h01);
        tick();
        chk("t6 irr refollow", irr, 8'h01);
        chk("t6 int_out blocked", 8'(int_out), 8'h00);
        ocw(8'h20);
        chk("t6 eoi isr", isr, 8'h00);
        tick();
        chk("t6 int_out again", 8'(int_out), 8'h01);
        first_ack = 1'b1;
        tick();
        first_ack = 1'b0;
        tick();
        second_ack = 1'b1;
        exp_q.push_back(3'd0);
        tick();
        chk("t6 int_valid", 8'(int_valid), 8'h01);
        init = 1'b1;
        tick();
        init = 1'b0;
        chk("init int_valid", 8'(int_valid), 8'h00);
        chk("init int_out", 8'(int_out), 8'h00);
        chk("init int_vec", 8'(int_vec), 8'h00);
        chk("init irr", irr, 8'h00);
        chk("init isr", isr, 8'h00);
        second_ack = 1'b0;
        ir   = 8'h00;
        ltim = 1'b0;
        tick(); tick();
        chk("scoreboard drained", 8'(exp_q.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
